// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter; optional input FIFO under UART_TX_FIFO_EN
module uart_tx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
   input  logic [1:0]           i_Parity_Mode,
   input  logic                 i_Two_Stop,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2) begin : g_bad_params
      $error("uart_tx_cfg: illegal DATA_BITS or FIFO_DEPTH");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
   logic [DIV_WIDTH-1:0] bit_idx_q, bit_idx_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 two_stop_q, two_stop_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   logic                 bit_end;
   logic                 last_stop;
   logic                 start_frame;
   logic [DATA_BITS-1:0] src_word;

   assign bit_end   = (clk_cnt_q == div_q - DIV_WIDTH'(1));
   assign last_stop = (state_q == S_STOP) && bit_end && (bit_idx_q == DIV_WIDTH'(two_stop_q));

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [AW:0]          count_q;
   logic                 fifo_empty, fifo_full, push, pop;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
   // A word leaves the FIFO whenever the shifter is free or finishing, so frames chain back-to-back
   assign pop         = !fifo_empty && ((state_q == S_IDLE) || last_stop);
   assign o_Tx_Ready  = !fifo_full || pop;
   assign push        = i_Tx_DV && o_Tx_Ready;
   assign start_frame = pop;
   assign src_word    = mem_q[rd_ptr_q];

   // FIFO storage, no reset needed since occupancy is tracked by count_q
   always_ff @(posedge i_Clock) begin
      if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
   end

   // FIFO pointers and occupancy; reset flushes the queue
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
`else
   assign o_Tx_Ready  = (state_q == S_IDLE);
   assign start_frame = i_Tx_DV && (state_q == S_IDLE);
   assign src_word    = i_Tx_Byte;
`endif

   // State and datapath registers, aborted immediately by reset
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         div_q      <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         div_q      <= div_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
      end
   end

   // Next state: walk START/DATA/PARITY/STOP, latching the frame format only at frame start
   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      div_d      = div_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      case (state_q)
         S_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               data_d    = data_q >> 1;
               if (bit_idx_q == DIV_WIDTH'(DATA_BITS - 1)) begin
                  bit_idx_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + DIV_WIDTH'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (last_stop) begin
                  bit_idx_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + DIV_WIDTH'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
            end
         end
         default: ;
      endcase
      if (start_frame) begin
         state_d    = S_START;
         clk_cnt_d  = '0;
         bit_idx_d  = '0;
         div_d      = (i_Clks_Per_Bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_Clks_Per_Bit;
         data_d     = src_word;
         par_en_d   = (i_Parity_Mode != 2'b00);
         case (i_Parity_Mode)
            2'b01:   par_bit_d = ~^src_word;
            2'b10:   par_bit_d = ^src_word;
            default: par_bit_d = 1'b0;
         endcase
         two_stop_d = i_Two_Stop;
      end
   end

   // Outputs: line level of the current state, registered one cycle later onto the pin
   always_comb begin
      serial_d = 1'b1;
      active_d = (state_q != S_IDLE);
      done_d   = last_stop;
      case (state_q)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = data_q[0];
         S_PARITY: serial_d = par_bit_q;
         default:  serial_d = 1'b1;
      endcase
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard testbench for uart_tx_cfg
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpb = 16'd4;
   logic [1:0]  pm = 2'b00;
   logic        ts = 1'b0;
   logic        dv = 1'b0;
   logic [7:0]  tx_byte = 8'h00;
   logic        ready, active, serial, done;

   always #5 clk = ~clk;

   uart_tx_cfg dut (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Clks_Per_Bit (cpb),
      .i_Parity_Mode  (pm),
      .i_Two_Stop     (ts),
      .i_Tx_DV        (dv),
      .i_Tx_Byte      (tx_byte),
      .o_Tx_Ready     (ready),
      .o_Tx_Active    (active),
      .o_Tx_Serial    (serial),
      .o_Tx_Done      (done)
   );

   typedef struct {
      logic [7:0] data;
      int         n;
      logic [1:0] pm;
      logic       ts;
   } frame_t;

   frame_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int frames = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int eff_n(input frame_t f);
      return (f.n < 2) ? 2 : f.n;
   endfunction

   function automatic int frame_len(input frame_t f);
      return eff_n(f) * (9 + ((f.pm != 2'b00) ? 1 : 0) + (f.ts ? 2 : 1));
   endfunction

   // Expected line level at cycle c (0 = first start-bit cycle) of frame f
   function automatic logic exp_line(input frame_t f, input int c);
      int b;
      b = c / eff_n(f);
      if (b == 0) return 1'b0;
      if (b <= 8) return f.data[b-1];
      if (f.pm != 2'b00 && b == 9) begin
         if (f.pm == 2'b01) return ~^f.data;
         if (f.pm == 2'b10) return ^f.data;
         return 1'b0;
      end
      return 1'b1;
   endfunction

   // Frame monitor: pops the scoreboard on each start bit and checks every cycle of the frame
   frame_t cur;
   int     c = 0;
   int     len = 0;
   bit     in_frame = 1'b0;
   bit     post = 1'b0;
   bit     bits_ok, done_ok, act_ok;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0;
         post     = 1'b0;
      end else begin
         if (!in_frame) begin
            if (post) begin
               post = 1'b0;
`ifdef UART_TX_FIFO_EN
               if (exp_q.size() > 0) check("fifo_no_gap", serial, 0);
`endif
               if (serial === 1'b1) begin
                  check("active_after_frame", active, 0);
                  check("done_one_cycle", done, 0);
               end
            end
            if (serial === 1'b0) begin
               check("start_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  cur      = exp_q.pop_front();
                  len      = frame_len(cur);
                  c        = 0;
                  in_frame = 1'b1;
                  bits_ok  = 1'b1;
                  done_ok  = 1'b1;
                  act_ok   = 1'b1;
               end
            end
         end
         if (in_frame) begin
            if (serial !== exp_line(cur, c)) bits_ok = 1'b0;
            if (done !== (c == len - 1)) done_ok = 1'b0;
            if (active !== 1'b1) act_ok = 1'b0;
            c++;
            if (c == len) begin
               in_frame = 1'b0;
               post     = 1'b1;
               check($sformatf("frame_%02h_n%0d_pm%0d_ts%0d_bits", cur.data, cur.n, cur.pm, cur.ts), bits_ok, 1);
               check($sformatf("frame_%02h_done_timing", cur.data), done_ok, 1);
               check($sformatf("frame_%02h_active", cur.data), act_ok, 1);
            end
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic send(input logic [7:0] d, input int n, input logic [1:0] p, input logic s);
      int t;
      t = 0;
      while (ready !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", t < 2000, 1);
      dv      = 1'b1;
      tx_byte = d;
      cpb     = 16'(n);
      pm      = p;
      ts      = s;
      exp_q.push_back('{data: d, n: n, pm: p, ts: s});
      frames++;
      @(negedge clk);
      dv = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(active === 1'b0 && ready === 1'b1 && !in_frame && exp_q.size() == 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", t < 5000, 1);
      repeat (2) @(negedge clk);
   endtask

   int done_before;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_serial", serial, 1);
      check("rst_active", active, 0);
      check("rst_done", done, 0);
      check("rst_ready", ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", ready, 1);

      // 0xA5, divisor 4, no parity, one stop: 40-cycle frame, latency check
      send(8'hA5, 4, 2'b00, 1'b0);
      check("lat_accept_edge", serial, 1);
`ifndef UART_TX_FIFO_EN
      check("ready_low_busy", ready, 0);
`else
      @(negedge clk);
      check("lat_fifo_second", serial, 1);
`endif
      @(negedge clk);
      check("lat_fall", serial, 0);
`ifndef UART_TX_FIFO_EN
      // DV while busy must be ignored; an accepted word would show up as an unexpected frame
      repeat (5) @(negedge clk);
      check("ready_low_ignored_dv", ready, 0);
      dv      = 1'b1;
      tx_byte = 8'h00;
      @(negedge clk);
      dv = 1'b0;
`endif
      wait_idle();

      // Even then odd parity on the same word
      send(8'hA5, 4, 2'b10, 1'b0);
      wait_idle();
      send(8'hA5, 4, 2'b01, 1'b0);
      wait_idle();

      // Two stop bits at divisor 3
      send(8'hFF, 3, 2'b00, 1'b1);
      wait_idle();

      // Divisors 0 and 1 behave as 2, with space parity
      send(8'h33, 1, 2'b11, 1'b0);
      wait_idle();
      send(8'hC3, 0, 2'b01, 1'b1);
      wait_idle();

      // Divisor changed mid-frame only affects the next frame
      send(8'h5C, 4, 2'b00, 1'b0);
      repeat (6) @(negedge clk);
      cpb = 16'd8;
      wait_idle();
      send(8'h69, 8, 2'b00, 1'b0);
      wait_idle();

      // Reset during bit 3 of 0x3C aborts the frame with no Done
      done_before = done_cnt;
      send(8'h3C, 4, 2'b00, 1'b0);
      frames--;
      repeat (17) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_serial", serial, 1);
      check("abort_active", active, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt, done_before);
      send(8'h96, 4, 2'b10, 1'b0);
      wait_idle();
      check("after_abort_done", done_cnt, done_before + 1);

`ifdef UART_TX_FIFO_EN
      // Shifter busy, then 4 pushes fill the FIFO; the 5th rides on the pop
      send(8'h11, 2, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fifo_ready_push%0d", i), ready, 1);
         dv      = 1'b1;
         tx_byte = 8'h21 + 8'(i);
         exp_q.push_back('{data: 8'h21 + 8'(i), n: 2, pm: 2'b00, ts: 1'b0});
         frames++;
         @(negedge clk);
      end
      dv = 1'b0;
      check("fifo_full_ready", ready, 0);
      send(8'h25, 2, 2'b00, 1'b0);
      wait_idle();
`endif

      check("done_count", done_cnt, frames);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Next-generation UART transmitter.
- Adds a parameterised data width, runtime baud divisor, runtime parity and stop-bit selection, and a valid/ready input handshake.
- Sits between the byte producers (packet formatters, debug streamers) and the board TX pin, replacing the fixed 8N1 transmitter in new designs.
- Frame format is fixed for the duration of each frame.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9; sent LSB first.
- DIV_WIDTH, 16: width of the runtime clocks-per-bit divisor.
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2; used only when UART_TX_FIFO_EN is defined.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Clks_Per_Bit  in  DIV_WIDTH  clock cycles per bit; values 0 and 1 are treated as 2.
- i_Parity_Mode  in  2  00 = none, 01 = odd, 10 = even, 11 = space (constant 0).
- i_Two_Stop  in  1  0 = one stop bit, 1 = two stop bits.
- i_Tx_DV  in  1  input data valid.
- i_Tx_Byte  in  DATA_BITS  data word to send.
- o_Tx_Ready  out  1  block can accept a word this cycle.
- o_Tx_Active  out  1  a frame is on the line.
- o_Tx_Serial  out  1  serial output, registered.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; counters = 0.
  - o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Ready = 1.
- Handshake:
  - A word is accepted on a rising edge where i_Tx_DV && o_Tx_Ready.
  - i_Tx_DV while o_Tx_Ready = 0 is ignored; there is no error flag.
- Config sampling: i_Clks_Per_Bit, i_Parity_Mode and i_Two_Stop are sampled only at frame start. Changes mid-frame have no effect until the next frame.
- Parity: computed once at frame start from the full DATA_BITS word.
  - Even: XOR of the data bits.
  - Odd: inverted XOR.
  - Space: 0.
- State machine, each bit held for exactly N = max(i_Clks_Per_Bit, 2) cycles:
  - IDLE: line = 1. On frame start go to START.
  - START: line = 0 for N cycles, then DATA.
  - DATA: bit[idx] for N cycles each, idx 0..DATA_BITS-1. Then PARITY if parity mode ≠ 00, else STOP.
  - PARITY: parity bit for N cycles, then STOP.
  - STOP: line = 1 for N cycles, or 2N if two stop bits. On the final STOP cycle, o_Tx_Done = 1 for that cycle only, then IDLE.
- Latency: for a word accepted at edge k, o_Tx_Serial falls at edge k+1.
- Frame length: N × (1 + DATA_BITS + P + S) cycles, where P = 0 or 1 (parity) and S = 1 or 2 (stop bits).
- o_Tx_Active is high from the first START cycle through the last STOP cycle.
- o_Tx_Ready without the FIFO: high only in IDLE. The earliest next acceptance is the cycle after Done, giving one idle-high cycle between frames.
- The bit counter and divisor counter are DIV_WIDTH bits; there is no wrap at the maximum divisor of 2^DIV_WIDTH−1.
- Reset mid-frame aborts immediately: line returns to 1, no Done pulse, the partially sent word is lost.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- When defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the shifter.
  - o_Tx_Ready = FIFO not full.
  - A push while full is ignored.
  - Simultaneous push and pop when full is allowed: the pop frees the slot in the same cycle.
  - If the FIFO is non-empty at the final STOP cycle, the next START begins on the following cycle, with no idle gap.
  - An empty FIFO plus an idle shifter gives IDLE.
  - Reset flushes the FIFO.
  - Frame-start latency from acceptance into an empty FIFO with an idle shifter is 2 cycles.
- When undefined: no FIFO, behaviour exactly as described above.

Test Plan:
- Divisor 4, parity 00, one stop, word 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; Done pulses once at cycle 40.
- Same word, parity 10 (even) then 01 (odd) -> parity bit 0 then 1; 44-cycle frames.
- Divisor 3, two stop bits, 0xFF -> stop level high for 6 cycles; o_Tx_Active falls with Done.
- Divisor changed from 4 to 8 mid-frame -> current frame stays at 4 cycles per bit; next frame uses 8.
- Reset asserted in bit 3 of 0x3C -> o_Tx_Serial = 1 and o_Tx_Active = 0 asynchronously; no Done pulse; the next word sends cleanly.
- UART_TX_FIFO_EN, depth 4, push 5 words back-to-back -> o_Tx_Ready drops after 4 pushes; the 5th is accepted once a pop occurs; 5 frames go out with no idle gap; 5 Done pulses.
